// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-lane data memory: access-size encoding,
// byte count per access and the lane-enable mask for a given size and offset.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} dmem_size_e;

    // A word access covers every lane, so its byte count follows the lane count.
    function automatic logic [3:0] byte_count(input dmem_size_e size, input int lanes);
        case (size)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'(lanes);
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input dmem_size_e size, input logic [2:0] off,
                                             input int lanes);
        logic [7:0] m;
        int         n;
        m = '0;
        n = int'(byte_count(size, lanes));
        for (int k = 0; k < 8; k++) begin
            if (k < n) m[3'((int'(off) + k) % lanes)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ram_lane_8xn.sv
// One 8-bit memory bank: synchronous write with enable, registered read with enable.
// Contents are never reset.
module ram_lane_8xn #(
  parameter int    DEPTH     = 16384,
  parameter string INIT_FILE = "",
  parameter int    LANE_ID   = 0
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [7:0]               i_wdata,
  output logic [7:0]               o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_q;

  // Read samples the array before this edge's write lands: read-first.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_addr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dmem_lane_ram.sv
// Byte-lane data memory: LANES 8-bit banks, byte/half/word access with lane rotation.
// Define DMEM_MISALIGN_EN to accept misaligned (lane-crossing) accesses; otherwise they return an error.
module dmem_lane_ram import dmem_pkg::*; #(
    parameter int    LANES     = 4,
    parameter int    DEPTH     = 16384,
    parameter int    ADDR_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [1:0]           req_size_i,
    input  logic [ADDR_W-1:0]    req_addr_i,
    input  logic [8*LANES-1:0]   req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [8*LANES-1:0]   rsp_rdata_o,
    output logic                 rsp_err_o
);

    localparam int OFF_W  = $clog2(LANES);
    localparam int WORD_W = $clog2(DEPTH);
    localparam int DW     = 8 * LANES;

    logic [OFF_W-1:0]  w_off;
    logic [WORD_W-1:0] w_word;
    logic [3:0]        w_n;
    logic [LANES-1:0]  w_mask;
    logic              w_rsv;
    logic              w_misalign;
    logic              w_err;
    logic              w_accept;
    logic [7:0]        w_lane_q [LANES];
    logic [DW-1:0]     w_rdata;

    logic              r_valid;
    logic              r_err;
    logic              r_load;
    logic [OFF_W-1:0]  r_off;
    logic [3:0]        r_n;

    assign w_off  = req_addr_i[OFF_W-1:0];
    assign w_word = req_addr_i[OFF_W +: WORD_W];
    assign w_n    = byte_count(dmem_size_e'(req_size_i), LANES);
    assign w_mask = LANES'(lane_mask(dmem_size_e'(req_size_i), 3'(w_off), LANES));
    assign w_rsv  = (req_size_i == SZ_RSV);

`ifdef DMEM_MISALIGN_EN
    assign w_misalign = 1'b0;
`else
    assign w_misalign = (4'(w_off) & (w_n - 4'd1)) != 4'd0;
`endif

    assign w_err = w_rsv | w_misalign;

    // Handshake: a request transfers on req_valid_i & req_ready_o, a response on
    // rsp_valid_o & rsp_ready_i; a new request may enter while the old response leaves.
    assign req_ready_o = !r_valid | rsp_ready_i;
    assign w_accept    = req_valid_i & req_ready_o & !rst_i;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [OFF_W-1:0]  w_k;
        logic [WORD_W-1:0] w_addr;
        logic              w_we;
        logic              w_re;

        // Lanes below the offset hold the bytes that spill into the next word.
        assign w_k    = OFF_W'(l) - w_off;
        assign w_addr = (OFF_W'(l) < w_off) ? w_word + WORD_W'(1) : w_word;
        assign w_we   = w_accept & req_we_i & !w_err & w_mask[l];
        assign w_re   = w_accept & !req_we_i;

        ram_lane_8xn #(
            .DEPTH     (DEPTH),
            .INIT_FILE (INIT_FILE),
            .LANE_ID   (l)
        ) u_lane (
            .i_clk   (clk_i),
            .i_we    (w_we),
            .i_re    (w_re),
            .i_addr  (w_addr),
            .i_wdata (req_wdata_i[8*w_k +: 8]),
            .o_rdata (w_lane_q[l])
        );
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_load  <= 1'b0;
            r_off   <= '0;
            r_n     <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_err   <= w_err;
            r_load  <= !req_we_i;
            r_off   <= w_off;
            r_n     <= w_n;
        end else if (rsp_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Rotate lane outputs back to byte 0 and zero everything past the access size.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_load && !r_err && (k < int'(r_n))) begin
                w_rdata[8*k +: 8] = w_lane_q[OFF_W'(r_off + OFF_W'(k))];
            end
        end
    end

    assign rsp_valid_o = r_valid;
    assign rsp_err_o   = r_err;
    assign rsp_rdata_o = w_rdata;

endmodule
